program_store: RTL and testbench

//  Parametrised, run-time loadable instruction store for the CPU fetch path; replaces the fixed case-table program ROMs.

---
 rtl/program_store.sv | 144 ++++++++++++++
 tb/tb_program_store.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_store.sv
// Run-time loadable instruction store: self-clears to NOP after reset, accepts a
// program over a valid/ready stream, and serves registered reads bounded by the program length.
module program_store #(
    parameter int                    DATA_WIDTH = 4,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(4'b0111)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addressIn,
    input  logic                  readEnable,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  dataValid,
    input  logic                  loadStart,
    input  logic                  loadValid,
    input  logic [DATA_WIDTH-1:0] loadData,
    input  logic                  loadLast,
    output logic                  loadReady,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   programLength,
    output logic                  truncated
);
    localparam int                DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_PTR = (ADDR_WIDTH+1)'(DEPTH - 1);

    typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_LOAD} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   clear_ptr_q, clear_ptr_d;
    logic [ADDR_WIDTH:0]   write_ptr_q, write_ptr_d;
    logic [ADDR_WIDTH:0]   prog_len_q, prog_len_d;
    logic                  truncated_q, truncated_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  load_ready_q, load_ready_d;
    logic                  busy_q, busy_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  rd_in_range;

    // Widened compare so a full-depth program still bounds address DEPTH-1 correctly.
    assign rd_in_range = {1'b0, addressIn} < prog_len_q;

    always_comb begin
        state_d      = state_q;
        clear_ptr_d  = clear_ptr_q;
        write_ptr_d  = write_ptr_q;
        prog_len_d   = prog_len_q;
        truncated_d  = truncated_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = '0;
        mem_wdata    = NOP_WORD;

        case (state_q)
            ST_CLEAR: begin
                mem_we      = 1'b1;
                mem_waddr   = clear_ptr_q[ADDR_WIDTH-1:0];
                mem_wdata   = NOP_WORD;
                clear_ptr_d = clear_ptr_q + 1'b1;
                if (clear_ptr_q == LAST_PTR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (readEnable) begin
                    data_out_d   = rd_in_range ? mem[addressIn] : NOP_WORD;
                    data_valid_d = 1'b1;
                end
                // A simultaneous read still sees the old length, since prog_len_q is used above.
                if (loadStart) begin
                    state_d     = ST_LOAD;
                    write_ptr_d = '0;
                    prog_len_d  = '0;
                    truncated_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (loadValid && load_ready_q) begin
                    mem_we      = 1'b1;
                    mem_waddr   = write_ptr_q[ADDR_WIDTH-1:0];
                    mem_wdata   = loadData;
                    prog_len_d  = write_ptr_q + 1'b1;
                    write_ptr_d = write_ptr_q + 1'b1;
                    if (loadLast) begin
                        state_d = ST_RUN;
                    end else if (write_ptr_q == LAST_PTR) begin
                        truncated_d = 1'b1;
                        state_d     = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        busy_d       = (state_d != ST_RUN);
        load_ready_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            clear_ptr_q  <= '0;
            write_ptr_q  <= '0;
            prog_len_q   <= '0;
            truncated_q  <= 1'b0;
            data_out_q   <= NOP_WORD;
            data_valid_q <= 1'b0;
            load_ready_q <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            clear_ptr_q  <= clear_ptr_d;
            write_ptr_q  <= write_ptr_d;
            prog_len_q   <= prog_len_d;
            truncated_q  <= truncated_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            load_ready_q <= load_ready_d;
            busy_q       <= busy_d;
        end
    end

    // Single write port with no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign dataOut       = data_out_q;
    assign dataValid     = data_valid_q;
    assign loadReady     = load_ready_q;
    assign busy          = busy_q;
    assign programLength = prog_len_q;
    assign truncated     = truncated_q;
endmodule

// File: tb/tb_program_store.sv
// Self-checking bench for program_store (16 x 4 store): table vectors for reads plus
// a read scoreboard that checks data and one-cycle latency.
module tb_program_store;
    localparam int         DW    = 4;
    localparam int         AW    = 4;
    localparam int         DEPTH = 16;
    localparam logic [3:0] NOP   = 4'b0111;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] addressIn;
    logic          readEnable;
    logic [DW-1:0] dataOut;
    logic          dataValid;
    logic          loadStart;
    logic          loadValid;
    logic [DW-1:0] loadData;
    logic          loadLast;
    logic          loadReady;
    logic          busy;
    logic [AW:0]   programLength;
    logic          truncated;

    program_store #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset), .addressIn(addressIn), .readEnable(readEnable),
        .dataOut(dataOut), .dataValid(dataValid), .loadStart(loadStart),
        .loadValid(loadValid), .loadData(loadData), .loadLast(loadLast),
        .loadReady(loadReady), .busy(busy), .programLength(programLength),
        .truncated(truncated)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        int         cyc;
    } rd_t;

    typedef struct {
        logic [3:0] addr;
        logic [3:0] data;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    rd_t        sb_q[$];
    logic [3:0] exp_mem[DEPTH];
    int         exp_len;
    vec_t       t2_vec[6];
    logic [3:0] t2_words[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] model_rd(input int a);
        return (a < exp_len) ? exp_mem[a] : NOP;
    endfunction

    task automatic sb_check();
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc - 1) begin
            rd_t e;
            e = sb_q.pop_front();
            chk("read_valid", dataValid, 1);
            chk("read_data", dataOut, e.data);
            $display("READ  cycle=%0d data=%h expected=%h valid=%0b", cyc, dataOut, e.data, dataValid);
        end else if (dataValid) begin
            chk("unexpected_valid", dataValid, 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        sb_check();
    endtask

    task automatic rd(input int a, input logic [3:0] e);
        addressIn  = 4'(a);
        readEnable = 1'b1;
        sb_q.push_back('{data: e, cyc: cyc});
        tick();
        readEnable = 1'b0;
    endtask

    task automatic start_load();
        loadStart = 1'b1;
        tick();
        loadStart = 1'b0;
        exp_len   = 0;
        chk("load_start_ready", loadReady, 1);
        chk("load_start_busy", busy, 1);
    endtask

    task automatic beat(input logic [3:0] d, input logic last);
        loadValid = 1'b1;
        loadData  = d;
        loadLast  = last;
        tick();
        loadValid = 1'b0;
        loadLast  = 1'b0;
        exp_mem[exp_len] = d;
        exp_len++;
        $display("LOAD  cycle=%0d word=%0d data=%h last=%0b", cyc, exp_len - 1, d, last);
    endtask

    task automatic wait_clear(output int n);
        n = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (!busy) break;
            n++;
        end
    endtask

    task automatic drain();
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; addressIn = '0; readEnable = 1'b0; loadStart = 1'b0;
        loadValid = 1'b0; loadData = '0; loadLast = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = NOP;
        exp_len = 0;

        t2_words = '{4'b0000, 4'b0001, 4'b1010, 4'b0010};
        t2_vec[0] = '{addr: 4'd4,  data: 4'b0111};
        t2_vec[1] = '{addr: 4'd15, data: 4'b0111};
        t2_vec[2] = '{addr: 4'd0,  data: 4'b0000};
        t2_vec[3] = '{addr: 4'd1,  data: 4'b0001};
        t2_vec[4] = '{addr: 4'd3,  data: 4'b0010};
        t2_vec[5] = '{addr: 4'd2,  data: 4'b1010};

        // 1: reset state, CLEAR duration with reads/loads ignored, then all-NOP reads
        tick();
        tick();
        chk("rst_busy", busy, 1);
        chk("rst_len", programLength, 0);
        chk("rst_trunc", truncated, 0);
        chk("rst_dout", dataOut, NOP);
        chk("rst_valid", dataValid, 0);
        chk("rst_ready", loadReady, 0);
        reset = 1'b0;
        readEnable = 1'b1;
        loadStart = 1'b1;
        wait_clear(n);
        readEnable = 1'b0;
        loadStart = 1'b0;
        chk("clear_busy_cycles", n, 16);
        tick();
        chk("run_ready", loadReady, 0);
        chk("run_busy", busy, 0);
        for (int a = 0; a < DEPTH; a++) rd(a, NOP);
        drain();

        // 2: short program, table-driven reads
        start_load();
        for (int i = 0; i < 4; i++) beat(t2_words[i], i == 3);
        chk("t2_len", programLength, 4);
        chk("t2_trunc", truncated, 0);
        chk("t2_ready", loadReady, 0);
        chk("t2_busy", busy, 0);
        for (int i = 0; i < 6; i++) rd(int'(t2_vec[i].addr), t2_vec[i].data);
        tick();
        tick();
        chk("t2_hold_dout", dataOut, 4'b1010);
        chk("t2_hold_valid", dataValid, 0);

        // 3: full depth without loadLast -> truncated
        start_load();
        for (int i = 0; i < DEPTH; i++) beat(4'(i) ^ 4'b0101, 1'b0);
        chk("t3_trunc", truncated, 1);
        chk("t3_len", programLength, 16);
        chk("t3_ready", loadReady, 0);
        chk("t3_busy", busy, 0);
        rd(0, model_rd(0));
        rd(9, model_rd(9));
        rd(15, model_rd(15));
        drain();

        // 4: long program then a short one; stale words must read as NOP
        start_load();
        for (int i = 0; i < 8; i++) beat(4'(15 - i), i == 7);
        chk("t4_len8", programLength, 8);
        start_load();
        beat(4'b1011, 1'b0);
        beat(4'b1110, 1'b1);
        chk("t4_len2", programLength, 2);
        chk("t4_trunc", truncated, 0);
        rd(5, 4'b0111);
        rd(0, model_rd(0));
        rd(1, model_rd(1));
        drain();

        // 5: gappy loadValid with readEnable/loadStart held, loadLast without valid
        start_load();
        for (int c = 0; c < 7; c++) begin
            loadValid  = (c % 2 == 0);
            loadData   = 4'(c + 3);
            loadLast   = (c == 6) || (c == 3);
            readEnable = 1'b1;
            loadStart  = 1'b1;
            addressIn  = 4'(c);
            tick();
            if (c % 2 == 0) begin
                exp_mem[exp_len] = 4'(c + 3);
                exp_len++;
                $display("LOAD  cycle=%0d word=%0d data=%h last=%0b", cyc, exp_len - 1, 4'(c + 3), c == 6);
            end
            if (c < 6) chk("t5_ready", loadReady, 1);
        end
        loadValid = 1'b0; loadLast = 1'b0; readEnable = 1'b0; loadStart = 1'b0;
        chk("t5_len", programLength, 4);
        chk("t5_trunc", truncated, 0);
        chk("t5_ready_end", loadReady, 0);
        for (int a = 0; a < 5; a++) rd(a, model_rd(a));
        drain();

        // 6: read and loadStart together, then reset mid-load
        addressIn  = 4'd2;
        readEnable = 1'b1;
        loadStart  = 1'b1;
        sb_q.push_back('{data: model_rd(2), cyc: cyc});
        tick();
        readEnable = 1'b0;
        loadStart  = 1'b0;
        exp_len    = 0;
        chk("t6_ready", loadReady, 1);
        chk("t6_len0", programLength, 0);
        beat(4'b1001, 1'b0);
        beat(4'b1000, 1'b0);
        beat(4'b0110, 1'b0);
        reset = 1'b1;
        tick();
        chk("t6_rst_busy", busy, 1);
        chk("t6_rst_len", programLength, 0);
        chk("t6_rst_dout", dataOut, NOP);
        chk("t6_rst_ready", loadReady, 0);
        chk("t6_rst_valid", dataValid, 0);
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = NOP;
        exp_len = 0;
        wait_clear(n);
        chk("t6_clear_cycles", n, 16);
        for (int a = 0; a < DEPTH; a++) rd(a, NOP);
        drain();

        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
